wb_sram_responder: RTL and testbench

//  Wishbone classic slave (responder) backed by an on-chip word-addressed RAM.

---
 rtl/wb_sram_responder.sv | 142 ++++++++++++++
 tb/tb_wb_sram_responder.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_sram_responder.sv
// Wishbone classic responder backed by a word-addressed RAM, with programmable wait states.
// Define WB_SRAM_ERR_EN to answer out-of-range requests with wb_err_o instead of aliasing.
`timescale 1ns/1ps
module wb_sram_responder #(
    parameter int          DEPTH       = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          WAIT_CYCLES = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wb_cyc_i,
    input  logic        wb_stb_i,
    input  logic        wb_we_i,
    input  logic [3:0]  wb_sel_i,
    input  logic [31:0] wb_addr_i,
    input  logic [31:0] wb_data_i,
    output logic [31:0] wb_data_o,
    output logic        wb_ack_o,
    output logic        wb_err_o,
    output logic [1:0]  dbg_state_o
);

    localparam int AW = $clog2(DEPTH);
`ifdef WB_SRAM_ERR_EN
    localparam logic ERR_EN = 1'b1;
`else
    localparam logic ERR_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    // Handshake: a request is cyc&stb sampled in IDLE; it is answered by exactly one
    // cycle of ack (or err) in RESP, after which the FSM always spends one cycle in IDLE.
    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        we_q;
    logic [3:0]  sel_q;
    logic [AW-1:0] idx_q;
    logic [31:0] wdat_q;
    logic        oor_q;
    logic [31:0] data_q;
    logic [31:0] ram [DEPTH];

    logic [31:0]   off;
    logic [AW-1:0] in_idx;
    logic          in_oor;
    logic          req;
    logic          capture;
    logic [AW-1:0] rd_idx;
    logic          rd_blk;
    logic          resp_blk;

    assign off     = wb_addr_i - BASE_ADDR;
    assign in_idx  = off[AW+1:2];
    // Unsigned wrap makes addresses below BASE_ADDR land far above the window too.
    assign in_oor  = (off >= 32'(DEPTH * 4));
    assign req     = wb_cyc_i & wb_stb_i;
    assign capture = (state_q == S_IDLE) && req;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (req) begin
                    if (WAIT_CYCLES > 0) begin
                        state_d = S_WAIT;
                        cnt_d   = 4'(WAIT_CYCLES - 1);
                    end else begin
                        state_d = S_RESP;
                    end
                end
            end
            S_WAIT: begin
                if (!req) begin
                    state_d = S_IDLE;
                    cnt_d   = 4'd0;
                end else if (cnt_q == 4'd0) begin
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // With no wait states the request is still on the bus when the read happens.
    assign rd_idx   = (state_q == S_IDLE) ? in_idx : idx_q;
    assign rd_blk   = ERR_EN & ((state_q == S_IDLE) ? in_oor : oor_q);
    assign resp_blk = ERR_EN & oor_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            data_q  <= 32'd0;
            we_q    <= 1'b0;
            sel_q   <= 4'd0;
            idx_q   <= '0;
            wdat_q  <= 32'd0;
            oor_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (capture) begin
                we_q   <= wb_we_i;
                sel_q  <= wb_sel_i;
                idx_q  <= in_idx;
                wdat_q <= wb_data_i;
                oor_q  <= in_oor;
            end
            if (state_d == S_RESP && state_q != S_RESP) begin
                data_q <= rd_blk ? 32'd0 : ram[rd_idx];
            end
        end
    end

    // Write commits on the edge that ends RESP, so a following read sees it.
    always_ff @(posedge clk) begin
        if (state_q == S_RESP && we_q && !resp_blk) begin
            for (int b = 0; b < 4; b++) begin
                if (sel_q[b]) ram[idx_q][8*b +: 8] <= wdat_q[8*b +: 8];
            end
        end
    end

    assign wb_data_o   = data_q;
    assign wb_ack_o    = (state_q == S_RESP) & ~resp_blk;
`ifdef WB_SRAM_ERR_EN
    assign wb_err_o    = (state_q == S_RESP) & oor_q;
`else
    assign wb_err_o    = 1'b0;
`endif
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_wb_sram_responder.sv
// Directed bench for wb_sram_responder: a zero-wait instance and a three-wait-state instance.
`timescale 1ns/1ps
module tb_wb_sram_responder;

    logic clk;
    logic rst;

    logic        cyc0, stb0, we0;
    logic [3:0]  sel0;
    logic [31:0] addr0, wdat0, rdat0;
    logic        ack0, err0;
    logic [1:0]  st0;

    logic        cyc3, stb3, we3;
    logic [3:0]  sel3;
    logic [31:0] addr3, wdat3, rdat3;
    logic        ack3, err3;
    logic [1:0]  st3;

    int checks;
    int failures;

    wb_sram_responder dut0 (
        .clk(clk), .rst(rst),
        .wb_cyc_i(cyc0), .wb_stb_i(stb0), .wb_we_i(we0), .wb_sel_i(sel0),
        .wb_addr_i(addr0), .wb_data_i(wdat0), .wb_data_o(rdat0),
        .wb_ack_o(ack0), .wb_err_o(err0), .dbg_state_o(st0)
    );

    wb_sram_responder #(
        .DEPTH(16), .BASE_ADDR(32'h0000_0100), .WAIT_CYCLES(3)
    ) dut3 (
        .clk(clk), .rst(rst),
        .wb_cyc_i(cyc3), .wb_stb_i(stb3), .wb_we_i(we3), .wb_sel_i(sel3),
        .wb_addr_i(addr3), .wb_data_i(wdat3), .wb_data_o(rdat3),
        .wb_ack_o(ack3), .wb_err_o(err3), .dbg_state_o(st3)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    // driver tasks
    task automatic drive(input int d, input logic c, input logic s, input logic w,
                         input logic [3:0] se, input logic [31:0] a, input logic [31:0] dt);
        if (d == 0) begin
            cyc0 = c; stb0 = s; we0 = w; sel0 = se; addr0 = a; wdat0 = dt;
        end else begin
            cyc3 = c; stb3 = s; we3 = w; sel3 = se; addr3 = a; wdat3 = dt;
        end
    endtask

    function automatic logic get_ack(input int d);
        return (d == 0) ? ack0 : ack3;
    endfunction

    function automatic logic get_err(input int d);
        return (d == 0) ? err0 : err3;
    endfunction

    function automatic logic [31:0] get_data(input int d);
        return (d == 0) ? rdat0 : rdat3;
    endfunction

    // lat = number of clock edges from the stb cycle until ack/err is seen; -1 on timeout
    task automatic bus_xfer(input int d, input logic w, input logic [31:0] a,
                            input logic [3:0] se, input logic [31:0] dt,
                            output logic [31:0] rd, output int lat, output logic e);
        rd  = 32'd0;
        lat = -1;
        e   = 1'b0;
        @(posedge clk); #1;
        drive(d, 1'b1, 1'b1, w, se, a, dt);
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk); #1;
            if (get_ack(d) || get_err(d)) begin
                lat = k;
                rd  = get_data(d);
                e   = get_err(d);
                break;
            end
        end
        drive(d, 1'b0, 1'b0, 1'b0, 4'h0, 32'd0, 32'd0);
    endtask

    task automatic test_reset;
        rst = 1'b0;
        drive(0, 1'b0, 1'b0, 1'b0, 4'h0, 32'd0, 32'd0);
        drive(1, 1'b0, 1'b0, 1'b0, 4'h0, 32'd0, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        checks++; if (ack0 !== 1'b0) begin failures++; $display("FAIL reset_ack0 got=%b exp=0", ack0); end
        checks++; if (err0 !== 1'b0) begin failures++; $display("FAIL reset_err0 got=%b exp=0", err0); end
        checks++; if (rdat0 !== 32'd0) begin failures++; $display("FAIL reset_data0 got=%h exp=0", rdat0); end
        checks++; if (st0 !== 2'd0) begin failures++; $display("FAIL reset_state0 got=%0d exp=0", st0); end
        checks++; if (ack3 !== 1'b0 || err3 !== 1'b0 || rdat3 !== 32'd0 || st3 !== 2'd0) begin
            failures++; $display("FAIL reset_dut3 got ack=%b err=%b data=%h st=%0d exp all 0", ack3, err3, rdat3, st3);
        end
        rst = 1'b1;
        repeat (2) @(posedge clk);
    endtask

    task automatic test_basic;
        logic [31:0] rd; int lat; logic e;
        bus_xfer(0, 1'b1, 32'h10, 4'hF, 32'hDEADBEEF, rd, lat, e);
        checks++; if (lat !== 1) begin failures++; $display("FAIL basic_wr_latency got=%0d exp=1", lat); end
        @(posedge clk); #1;
        checks++; if (ack0 !== 1'b0) begin failures++; $display("FAIL basic_ack_pulse got=%b exp=0", ack0); end
        bus_xfer(0, 1'b0, 32'h10, 4'h0, 32'd0, rd, lat, e);
        checks++; if (lat !== 1) begin failures++; $display("FAIL basic_rd_latency got=%0d exp=1", lat); end
        checks++; if (rd !== 32'hDEADBEEF) begin failures++; $display("FAIL basic_rd_data got=%h exp=deadbeef", rd); end
        repeat (2) @(posedge clk); #1;
        checks++; if (rdat0 !== 32'hDEADBEEF) begin failures++; $display("FAIL basic_data_hold got=%h exp=deadbeef", rdat0); end
    endtask

    task automatic test_byte_sel;
        logic [31:0] rd; int lat; logic e;
        bus_xfer(0, 1'b1, 32'h40, 4'hF, 32'h11223344, rd, lat, e);
        bus_xfer(0, 1'b1, 32'h40, 4'b0101, 32'hAABBCCDD, rd, lat, e);
        bus_xfer(0, 1'b0, 32'h43, 4'h0, 32'd0, rd, lat, e);
        checks++; if (rd !== 32'h11BB33DD) begin failures++; $display("FAIL bytesel_merge got=%h exp=11bb33dd", rd); end
        bus_xfer(0, 1'b1, 32'h40, 4'h0, 32'h0, rd, lat, e);
        checks++; if (lat !== 1) begin failures++; $display("FAIL bytesel_sel0_ack got_latency=%0d exp=1", lat); end
        bus_xfer(0, 1'b0, 32'h40, 4'h0, 32'd0, rd, lat, e);
        checks++; if (rd !== 32'h11BB33DD) begin failures++; $display("FAIL bytesel_sel0_nochange got=%h exp=11bb33dd", rd); end
    endtask

    task automatic test_wait_latency;
        logic [31:0] rd; int lat; logic e;
        bus_xfer(1, 1'b1, 32'h104, 4'hF, 32'hCAFE0001, rd, lat, e);
        checks++; if (lat !== 4) begin failures++; $display("FAIL wait_wr_latency got=%0d exp=4", lat); end
        @(posedge clk); #1;
        checks++; if (ack3 !== 1'b0) begin failures++; $display("FAIL wait_ack_pulse got=%b exp=0", ack3); end
        bus_xfer(1, 1'b1, 32'h100, 4'hF, 32'h12345678, rd, lat, e);
        bus_xfer(1, 1'b0, 32'h100, 4'h0, 32'd0, rd, lat, e);
        checks++; if (lat !== 4 || rd !== 32'h12345678) begin
            failures++; $display("FAIL wait_rd got latency=%0d data=%h exp 4/12345678", lat, rd);
        end
    endtask

    task automatic test_back_to_back;
        logic [12:0] hist;
        logic [31:0] d1, d2;
        int n;
        hist = '0; d1 = 32'd0; d2 = 32'd0; n = 0;
        @(posedge clk); #1;
        drive(1, 1'b1, 1'b1, 1'b0, 4'hF, 32'h104, 32'd0);
        for (int k = 1; k <= 12; k++) begin
            @(posedge clk); #1;
            if (ack3) begin
                hist[k] = 1'b1;
                n++;
                if (n == 1) d1 = rdat3;
                if (n == 2) begin
                    d2 = rdat3;
                    drive(1, 1'b0, 1'b0, 1'b0, 4'h0, 32'd0, 32'd0);
                end
            end
        end
        drive(1, 1'b0, 1'b0, 1'b0, 4'h0, 32'd0, 32'd0);
        checks++; if (hist !== 13'h210) begin failures++; $display("FAIL b2b_ack_cycles got=%b exp=%b", hist, 13'h210); end
        checks++; if (d1 !== 32'hCAFE0001 || d2 !== 32'hCAFE0001) begin
            failures++; $display("FAIL b2b_data got=%h,%h exp=cafe0001,cafe0001", d1, d2);
        end
    endtask

    task automatic test_abort;
        logic [31:0] rd; int lat; logic e;
        logic seen;
        logic [1:0] st_after;
        seen = 1'b0; st_after = 2'd3;
        @(posedge clk); #1;
        drive(1, 1'b1, 1'b1, 1'b1, 4'hF, 32'h100, 32'h00000055);
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk); #1;
            if (ack3 || err3) seen = 1'b1;
            if (k == 2) cyc3 = 1'b0;
            if (k == 3) st_after = st3;
        end
        drive(1, 1'b0, 1'b0, 1'b0, 4'h0, 32'd0, 32'd0);
        checks++; if (seen !== 1'b0) begin failures++; $display("FAIL abort_no_ack got=%b exp=0", seen); end
        checks++; if (st_after !== 2'd0) begin failures++; $display("FAIL abort_state got=%0d exp=0", st_after); end
        bus_xfer(1, 1'b0, 32'h100, 4'h0, 32'd0, rd, lat, e);
        checks++; if (rd !== 32'h12345678) begin failures++; $display("FAIL abort_no_write got=%h exp=12345678", rd); end
    endtask

    task automatic test_reset_mid;
        logic [31:0] rd; int lat; logic e;
        @(posedge clk); #1;
        drive(1, 1'b1, 1'b1, 1'b1, 4'hF, 32'h100, 32'hBAD0BAD0);
        repeat (2) begin @(posedge clk); #1; end
        rst = 1'b0;
        #1;
        checks++; if (st3 !== 2'd0) begin failures++; $display("FAIL rstmid_state got=%0d exp=0", st3); end
        checks++; if (ack3 !== 1'b0 || err3 !== 1'b0 || rdat3 !== 32'd0) begin
            failures++; $display("FAIL rstmid_outputs got ack=%b err=%b data=%h exp 0/0/0", ack3, err3, rdat3);
        end
        @(posedge clk); #1;
        drive(1, 1'b0, 1'b0, 1'b0, 4'h0, 32'd0, 32'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        bus_xfer(1, 1'b0, 32'h100, 4'h0, 32'd0, rd, lat, e);
        checks++; if (rd !== 32'h12345678) begin failures++; $display("FAIL rstmid_ram3 got=%h exp=12345678", rd); end
        bus_xfer(0, 1'b0, 32'h10, 4'h0, 32'd0, rd, lat, e);
        checks++; if (rd !== 32'hDEADBEEF) begin failures++; $display("FAIL rstmid_ram0 got=%h exp=deadbeef", rd); end
    endtask

    task automatic test_out_of_range;
        logic [31:0] rd; int lat; logic e;
        bus_xfer(0, 1'b1, 32'h0, 4'hF, 32'hA5A5A5A5, rd, lat, e);
        bus_xfer(0, 1'b1, 32'h1000, 4'hF, 32'h01020304, rd, lat, e);
        checks++; if (lat !== 1) begin failures++; $display("FAIL oor_latency got=%0d exp=1", lat); end
`ifdef WB_SRAM_ERR_EN
        checks++; if (e !== 1'b1 || rd !== 32'd0) begin
            failures++; $display("FAIL oor_err got err=%b data=%h exp 1/0", e, rd);
        end
        bus_xfer(0, 1'b0, 32'h0, 4'h0, 32'd0, rd, lat, e);
        checks++; if (rd !== 32'hA5A5A5A5) begin failures++; $display("FAIL oor_word0 got=%h exp=a5a5a5a5", rd); end
`else
        checks++; if (e !== 1'b0) begin failures++; $display("FAIL oor_err got=%b exp=0", e); end
        bus_xfer(0, 1'b0, 32'h0, 4'h0, 32'd0, rd, lat, e);
        checks++; if (rd !== 32'h01020304) begin failures++; $display("FAIL oor_alias got=%h exp=01020304", rd); end
`endif
    endtask

    initial begin
        checks = 0;
        failures = 0;
        test_reset();
        test_basic();
        test_byte_sel();
        test_wait_latency();
        test_back_to_back();
        test_abort();
        test_reset_mid();
        test_out_of_range();
        repeat (2) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
